// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
//
// Destination side of a 4-phase request/acknowledge clock-domain crossing.
// The asynchronous src_req is synchronised into dst_clk. When a request is
// seen and the one-word output buffer can accept it, src_data is captured. The
// captured word is then presented on out_data/out_valid, and dst_ack is raised.
// dst_ack stays high until the synchronised request returns low.
//
// Ports
//   dst_clk    in   1       destination clock, rising-edge
//   rst_n      in   1       asynchronous active-low reset
//   src_req    in   1       asynchronous 4-phase request
//   src_data   in   DATA_W  source word, stable while src_req is high
//   dst_ack    out  1       registered 4-phase acknowledge
//   out_data   out  DATA_W  captured word
//   out_valid  out  1       out_data holds an unconsumed word
//   out_ready  in   1       downstream accepts when out_valid && out_ready
//   busy       out  1       FSM is not idle
//   xfer_cnt   out  16      number of completed captures (wraps)
// -----------------------------------------------------------------------------
module cdc_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              dst_clk,
    input  logic              rst_n,
    input  logic              src_req,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       xfer_cnt
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("cdc_handshake_rx: SYNC_STAGES must be at least 2");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_BUF = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;

    // -------------------------------------------------------------------------
    // Request synchroniser. This is the only logic that samples src_req.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // flop then samples the values from before the edge, which is
            // what lets the shift chain move one stage per clock.
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Handshake FSM and output buffer
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic              ack_q,      ack_d;
    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [15:0]       cnt_q,      cnt_d;
    logic              buf_free;
    logic              capture;

    always_comb begin
        // NOTE: every signal assigned here gets a default before the case.
        // A path that leaves a signal unassigned would infer a latch.
        state_d  = state_q;
        ack_d    = ack_q;
        valid_d  = valid_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        buf_free = !valid_q || out_ready;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (buf_free) capture = 1'b1;
                    else          state_d = ST_WAIT_BUF;
                end
            end
            ST_WAIT_BUF: begin
                // If the source drops its request before we captured, that is
                // a protocol violation. The word is abandoned and ack is
                // never raised.
                if (!req_s)        state_d = ST_IDLE;
                else if (buf_free) capture = 1'b1;
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The consumer drains the buffer first. A capture on the same edge
        // takes priority, so out_valid stays high with the new word.
        if (valid_q && out_ready) valid_d = 1'b0;

        if (capture) begin
            data_d  = src_data;
            valid_d = 1'b1;
            ack_d   = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_ACK;
        end
    end

    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset along with the control
            // state. out_data then reads a defined zero after reset instead
            // of stale contents.
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // dst_ack leaves the module straight from its flop, so no combinational
    // glitch can reach the source domain.
    assign dst_ack   = ack_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign xfer_cnt  = cnt_q;

endmodule
